// File: rtl/nv_nvdla_mcif_read_eg_rsp_pipe.sv
// Read-return egress pipe: 2-entry registered FIFO from NoC beats to DMA responses, plus outstanding-beat tracking.
// Optional error flags are built in when NVDLA_MCIF_RSP_ERR_CHK_EN is defined.
module nv_nvdla_mcif_read_eg_rsp_pipe #(
    parameter int DW     = 512,
    parameter int SIZE_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              req_accept,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              noc2mcif_rd_valid,
    output logic              noc2mcif_rd_ready,
    input  logic [DW-1:0]     noc2mcif_rd_data,
    output logic              mcif2dma_rsp_valid,
    input  logic              mcif2dma_rsp_ready,
    output logic [DW-1:0]     mcif2dma_rsp_pd,
    output logic [CNT_W-1:0]  outstanding_beats,
    output logic              idle
`ifdef NVDLA_MCIF_RSP_ERR_CHK_EN
    ,
    output logic              err_unexp_beat,
    output logic              err_cnt_ovf
`endif
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    // Handshakes: a beat transfers on an edge where valid and ready are both high;
    // valid never waits on ready, and both ready/valid here derive from registers only.
    logic [1:0]    count;
    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic          push;
    logic          pop;

    assign noc2mcif_rd_ready  = (count != 2'd2);
    assign mcif2dma_rsp_valid = (count != 2'd0);
    assign mcif2dma_rsp_pd    = head_q;
    assign push = noc2mcif_rd_valid & noc2mcif_rd_ready;
    assign pop  = mcif2dma_rsp_valid & mcif2dma_rsp_ready;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage is not reset; contents only matter while count says they are valid.
    always_ff @(posedge nvdla_core_clk) begin
        if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
            head_q <= noc2mcif_rd_data;
        end else if (pop && count == 2'd2) begin
            head_q <= tail_q;
        end
        if (push && count == 2'd1 && !pop) begin
            tail_q <= noc2mcif_rd_data;
        end
    end

    logic [CNT_W:0]   credit;
    logic [CNT_W:0]   gross;
    logic [CNT_W:0]   net;
    logic             cnt_unf;
    logic             cnt_ovf;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        credit   = '0;
        if (req_accept) begin
            credit = {{(CNT_W + 1 - SIZE_W){1'b0}}, req_size} + {{CNT_W{1'b0}}, 1'b1};
        end
        gross    = {1'b0, outstanding_beats} + credit;
        cnt_unf  = push && (gross == '0);
        net      = gross - {{CNT_W{1'b0}}, push};
        cnt_ovf  = !cnt_unf && (net > CNT_MAX);
        cnt_next = net[CNT_W-1:0];
        if (cnt_unf) begin
            cnt_next = '0;
        end else if (cnt_ovf) begin
            cnt_next = {CNT_W{1'b1}};
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            outstanding_beats <= '0;
        end else begin
            outstanding_beats <= cnt_next;
        end
    end

    assign idle = (outstanding_beats == '0) && (count == 2'd0);

`ifdef NVDLA_MCIF_RSP_ERR_CHK_EN
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            err_unexp_beat <= 1'b0;
            err_cnt_ovf    <= 1'b0;
        end else begin
            if (cnt_unf) err_unexp_beat <= 1'b1;
            if (cnt_ovf) err_cnt_ovf    <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_read_eg_rsp_pipe.sv
// Bench for nv_nvdla_mcif_read_eg_rsp_pipe: directed plan steps then random traffic against a queue/integer model.
module tb_nv_nvdla_mcif_read_eg_rsp_pipe;

    localparam int DW     = 512;
    localparam int SIZE_W = 13;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_accept = 1'b0;
    logic [SIZE_W-1:0] req_size = '0;
    logic              rd_valid = 1'b0;
    logic              rd_ready;
    logic [DW-1:0]     rd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DW-1:0]     rsp_pd;
    logic [CNT_W-1:0]  outstanding;
    logic              idle;
`ifdef NVDLA_MCIF_RSP_ERR_CHK_EN
    logic              err_unexp_beat;
    logic              err_cnt_ovf;
`endif

    nv_nvdla_mcif_read_eg_rsp_pipe #(.DW(DW), .SIZE_W(SIZE_W), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rst     (rst),
        .req_accept         (req_accept),
        .req_size           (req_size),
        .noc2mcif_rd_valid  (rd_valid),
        .noc2mcif_rd_ready  (rd_ready),
        .noc2mcif_rd_data   (rd_data),
        .mcif2dma_rsp_valid (rsp_valid),
        .mcif2dma_rsp_ready (rsp_ready),
        .mcif2dma_rsp_pd    (rsp_pd),
        .outstanding_beats  (outstanding),
        .idle               (idle)
`ifdef NVDLA_MCIF_RSP_ERR_CHK_EN
        ,
        .err_unexp_beat     (err_unexp_beat),
        .err_cnt_ovf        (err_cnt_ovf)
`endif
    );

    // reference model: beats in flight as a queue, outstanding as a plain integer
    logic [DW-1:0] exp_q[$];
    int            m_cnt;
    bit            m_unexp;
    bit            m_ovf;
    int            compared = 0;
    int            mismatched = 0;

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_ready", DW'(rd_ready), DW'(exp_q.size() < 2));
        chk("rsp_valid", DW'(rsp_valid), DW'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("rsp_pd", rsp_pd, exp_q[0]);
        chk("outstanding", DW'(outstanding), DW'(m_cnt));
        chk("idle", DW'(idle), DW'(m_cnt == 0 && exp_q.size() == 0));
`ifdef NVDLA_MCIF_RSP_ERR_CHK_EN
        chk("err_unexp_beat", DW'(err_unexp_beat), DW'(m_unexp));
        chk("err_cnt_ovf", DW'(err_cnt_ovf), DW'(m_ovf));
`endif
    endtask

    // driver: one clock cycle of stimulus, called just after a falling edge
    task automatic cycle(input bit acc, input int size, input bit v, input logic [DW-1:0] d, input bit rr);
        bit p_push, p_pop;
        int total;
        req_accept = acc;
        req_size   = SIZE_W'(size);
        rd_valid   = v;
        rd_data    = d;
        rsp_ready  = rr;
        p_push = v && (exp_q.size() < 2);
        p_pop  = rr && (exp_q.size() > 0);
        @(posedge clk);
        if (p_pop) void'(exp_q.pop_front());
        if (p_push) exp_q.push_back(d);
        total = m_cnt + (acc ? size + 1 : 0);
        if (p_push) begin
            if (total == 0) m_unexp = 1'b1;
            else total = total - 1;
        end
        if (total > CMAX) begin
            total = CMAX;
            m_ovf = 1'b1;
        end
        m_cnt = total;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        exp_q.delete();
        m_cnt = 0;
        m_unexp = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    logic [DW-1:0] d;

    initial begin
        @(negedge clk);
        req_accept = 1'b0;
        rd_valid   = 1'b0;
        rsp_ready  = 1'b0;
        do_reset(2);

        // single request of 4 beats, back-to-back
        cycle(1, 3, 0, '0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, rnd_data(), 1);
        cycle(0, 0, 0, '0, 1);

        // backpressure: offer 3 beats with client stalled, then release
        cycle(1, 2, 0, '0, 0);
        cycle(0, 0, 1, rnd_data(), 0);
        cycle(0, 0, 1, rnd_data(), 0);
        d = rnd_data();
        cycle(0, 0, 1, d, 0);
        cycle(0, 0, 1, d, 0);
        cycle(0, 0, 1, d, 1);
        cycle(0, 0, 1, d, 1);
        repeat (3) cycle(0, 0, 0, '0, 1);

        // same-cycle credit and debit: 5 outstanding, +2 -1 -> 6
        cycle(1, 4, 0, '0, 1);
        cycle(1, 1, 1, rnd_data(), 1);
        repeat (6) cycle(0, 0, 1, rnd_data(), 1);
        cycle(0, 0, 0, '0, 1);

        // underflow: beat with nothing outstanding is still delivered
        cycle(0, 0, 1, rnd_data(), 1);
        cycle(0, 0, 0, '0, 1);

        // overflow: drive to 65534, then +8 saturates
        do_reset(1);
        for (int i = 0; i < 7; i++) cycle(1, 8191, 0, '0, 1);
        cycle(1, 8189, 0, '0, 1);
        cycle(1, 7, 0, '0, 1);
        cycle(0, 0, 1, rnd_data(), 1);
        cycle(0, 0, 0, '0, 1);

        // mid-operation reset with 2 beats buffered and 10 outstanding
        do_reset(1);
        cycle(1, 11, 0, '0, 0);
        cycle(0, 0, 1, rnd_data(), 0);
        cycle(0, 0, 1, rnd_data(), 0);
        rd_valid = 1'b1;
        rsp_ready = 1'b1;
        do_reset(1);
        rd_valid = 1'b0;
        repeat (3) cycle(0, 0, 0, '0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                  ($urandom_range(0, 1) == 1), rnd_data(), ($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 199) == 0) do_reset(1);
        end

        // drain and expect idle again
        rd_valid = 1'b0;
        repeat (4) cycle(0, 0, 0, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_mcif_read_eg_rsp_pipe.md
Name: nv_nvdla_mcif_read_eg_rsp_pipe

Overview:
Egress-side counterpart of the read-ingress request pipe.
- Accepts read-return data beats from the NoC and buffers them in a 2-entry ready/valid FIFO with registered outputs.
- Delivers the beats in order to the DMA client response interface.
- Tracks outstanding beats: credited by accepted DMA read requests, debited by returned beats. Reports an idle indication to the power/clock-gating and flush logic.

Parameters:
DW, 512, data width of NoC return beat and DMA response payload
SIZE_W, 13, width of request size field (size = beats minus 1)
CNT_W, 16, width of outstanding-beat counter

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  reset, synchronous, active-high
req_accept  in  1  one-cycle pulse: a dma2bpt read request handshake completed this cycle
req_size  in  SIZE_W  beats minus 1 of the accepted request; sampled only when req_accept=1
noc2mcif_rd_valid  in  1  NoC return beat valid
noc2mcif_rd_ready  out  1  NoC return beat ready
noc2mcif_rd_data  in  DW  NoC return beat data
mcif2dma_rsp_valid  out  1  response valid to DMA client
mcif2dma_rsp_ready  in  1  response ready from DMA client
mcif2dma_rsp_pd  out  DW  response payload
outstanding_beats  out  CNT_W  beats requested but not yet returned
idle  out  1  no outstanding beats and FIFO empty

Behaviour:
- One clock domain; all state updates on the rising edge of nvdla_core_clk.
- Reset (nvdla_core_rst=1 at an edge):
  - FIFO count=0, rsp_valid=0, noc2mcif_rd_ready=1, outstanding_beats=0, idle=1.
  - Data storage registers are not reset. rsp_pd is don't-care while rsp_valid=0.
- Reset asserted mid-operation: buffered beats are discarded and the counter clears at that edge. No beat is delivered afterwards.

FIFO (depth 2):
- Push = noc2mcif_rd_valid & noc2mcif_rd_ready.
- Pop = mcif2dma_rsp_valid & mcif2dma_rsp_ready.
- noc2mcif_rd_ready = (count != 2). It is a function of registered state only, with no combinational path from mcif2dma_rsp_ready.
- mcif2dma_rsp_valid = (count != 0); rsp_pd = head entry. Both come directly from registers.
- Latency: a beat pushed at edge N is visible on rsp_valid/rsp_pd after edge N, i.e. in cycle N+1.
- Simultaneous push and pop with count=1: count stays 1, head advances to the new beat.
- Push and pop are never simultaneous at count=2 (ready=0) or at count=0 (valid=0).
- Full throughput: 1 beat/cycle sustained while rsp_ready=1.
- Order strictly preserved. rsp_valid, once high, stays high with a stable pd until the pop.

Outstanding counter:
- Next value = cur + (req_accept ? req_size+1 : 0) - (push ? 1 : 0). Computed at CNT_W+1 bits.
- Credit and debit in the same cycle apply together (net change).
- Underflow (push while the net result would go below 0): counter holds at 0. The beat is still accepted and delivered.
- Overflow (result > 2^CNT_W-1): counter saturates at 2^CNT_W-1.
- idle = (outstanding_beats == 0) & (count == 0). Registered-state based; asserted after reset.

Optional Feature:
NVDLA_MCIF_RSP_ERR_CHK_EN
- Defined:
  - Adds output err_unexp_beat (1): sticky, sets the cycle after a push that hit the underflow case.
  - Adds output err_cnt_ovf (1): sticky, sets the cycle after saturation occurs.
  - Both cleared only by nvdla_core_rst.
- Undefined: both ports and their logic are absent. Saturation and hold-at-0 behaviour are unchanged.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> rd_ready=1, rsp_valid=0, outstanding_beats=0, idle=1.
- Single request: req_accept with req_size=3, then 4 beats D0..D3 back-to-back with rsp_ready=1 -> outstanding 4→3→2→1→0; rsp_pd D0..D3 in order, each 1 cycle after its push; idle=1 after the last pop.
- Backpressure: rsp_ready=0, 3 beats offered -> first 2 accepted, rd_ready=0 from the cycle after the 2nd push, rsp_pd stable at D0; raise rsp_ready -> D0, D1, D2 delivered in order with no loss.
- Same-cycle credit/debit: outstanding=5, req_accept size=1 together with a beat push -> outstanding=6 next cycle.
- Underflow/overflow: beat pushed with outstanding=0 -> counter stays 0, beat delivered, err_unexp_beat=1 next cycle (macro on). Counter at 65534 plus req_size=7 -> counter 65535, err_cnt_ovf=1.
- Mid-operation reset: 2 beats buffered, 10 outstanding, assert rst 1 cycle -> rsp_valid=0, outstanding=0, idle=1, no stale beat emitted after release.
